// File: rtl/switch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// switch_debounce_pkg
// Shared constants for the slide-switch input conditioner, plus a helper
// that picks the lowest set bit of a vector in the hexdigit code space.
// -----------------------------------------------------------------------------
package switch_debounce_pkg;

  localparam int unsigned SWDB_DB_CYCLES_DEFAULT = 250000;
  localparam logic [4:0]  SWDB_IDX_OFF           = 5'd20;  // hexdigit "blank"
  localparam int unsigned SWDB_WIDTH_DEFAULT     = 10;

  // Lowest index with its bit set, or the blank code when the vector is empty.
  function automatic logic [4:0] swdb_lowest_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = SWDB_IDX_OFF;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// -----------------------------------------------------------------------------
// switch_debounce_bit
// One switch channel: 2-flop synchroniser, stability counter, debounced level
// and registered one-cycle rise/fall pulses.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   pin      in   raw switch pin (asynchronous to clk)
//   state    out  debounced level
//   rise     out  one-cycle pulse on an accepted 0->1 change
//   fall     out  one-cycle pulse on an accepted 1->0 change
//   event_d  out  next-cycle value of (rise | fall); lets the parent register
//                 its OR in the same cycle as the pulses
// -----------------------------------------------------------------------------
module switch_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = SWDB_DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic state,
  output logic rise,
  output logic fall,
  output logic event_d
);

  // The counter tops out at DB_CYCLES-1, so it never needs to wrap.
  localparam int unsigned     CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             state_q, state_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sync1_d = pin;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Level has differed for DB_CYCLES consecutive cycles: accept it.
      state_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state   = state_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign event_d = rise_d | fall_d;

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Synchronises and debounces the slide switches, producing a stable level
// vector plus registered one-cycle rise/fall pulses and their OR.
//
// Optional feature macro: SWITCH_DEBOUNCE_LASTIDX_EN adds last_idx, the index
// of the most recently changed switch in hexdigit code (20 = blank).
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   stswi     in   raw switch pins [WIDTH]
//   sw_state  out  debounced levels [WIDTH]
//   sw_rise   out  accepted 0->1 pulses [WIDTH]
//   sw_fall   out  accepted 1->0 pulses [WIDTH]
//   sw_any    out  OR of all pulses, same cycle
//   last_idx  out  last changed switch index [5] (macro only)
// -----------------------------------------------------------------------------
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH     = SWDB_WIDTH_DEFAULT,
  parameter int unsigned DB_CYCLES = SWDB_DB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] stswi,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
  ,
  output logic [4:0]       last_idx
`endif
);

  logic [WIDTH-1:0] event_d;
  logic             sw_any_q, sw_any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .pin    (stswi[i]),
      .state  (sw_state[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i]),
      .event_d(event_d[i])
    );
  end

  // Built from next-state pulses so the registered OR lines up with them.
  always_comb begin
    sw_any_d = |event_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_any_q <= 1'b0;
    else     sw_any_q <= sw_any_d;
  end

  assign sw_any = sw_any_q;

`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
  logic [4:0] last_idx_q, last_idx_d;

  // Rises win over falls; within a group the lowest index wins.
  always_comb begin
    last_idx_d = last_idx_q;
    if (sw_any_q) begin
      last_idx_d = (|sw_rise) ? swdb_lowest_idx(32'(sw_rise))
                              : swdb_lowest_idx(32'(sw_fall));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_idx_q <= SWDB_IDX_OFF;
    else     last_idx_q <= last_idx_d;
  end

  assign last_idx = last_idx_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
// Scoreboard bench for switch_debounce (WIDTH=10, DB_CYCLES=4). A reference
// model keeps the history of sampled pin values and declares a switch accepted
// when the synchronised samples of the last DB_CYCLES cycles all agree and
// differ from the model's level. Expected outputs are queued per clock edge
// and a separate monitor pops and compares them. Directed checks cover the
// latency, bounce, glitch, simultaneous and mid-count reset scenarios.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int W  = 10;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] stswi = '0;
  logic [W-1:0] sw_state, sw_rise, sw_fall;
  logic         sw_any;
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
  logic [4:0]   last_idx;
`endif

  switch_debounce #(
    .WIDTH    (W),
    .DB_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stswi   (stswi),
    .sw_state(sw_state),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .sw_any  (sw_any)
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
    ,
    .last_idx(last_idx)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] state;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any;
    logic [4:0]   idx;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] hist [DB+2];   // hist[k] = pins sampled k edges ago (0 = this edge)
  logic [W-1:0] m_state = '0, m_rise = '0, m_fall = '0;
  logic [4:0]   m_idx = 5'd20;

  function automatic logic [4:0] lowest(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return 5'(i);
    return 5'd20;
  endfunction

  task automatic model_step();
    exp_t e;
    logic same;
    if (rst) begin
      for (int k = 0; k < DB + 2; k++) hist[k] = '0;
      m_state = '0; m_rise = '0; m_fall = '0; m_idx = 5'd20;
    end else begin
      // Index reflects the pulses shown during the previous cycle.
      if (|(m_rise | m_fall)) m_idx = (|m_rise) ? lowest(m_rise) : lowest(m_fall);
      for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = stswi;
      m_rise = '0;
      m_fall = '0;
      // Synchroniser delay is two edges, so the window is hist[2..DB+1].
      for (int b = 0; b < W; b++) begin
        same = 1'b1;
        for (int k = 3; k <= DB + 1; k++) if (hist[k][b] != hist[2][b]) same = 1'b0;
        if (same && hist[2][b] != m_state[b]) begin
          m_state[b] = hist[2][b];
          if (hist[2][b]) m_rise[b] = 1'b1;
          else            m_fall[b] = 1'b1;
        end
      end
    end
    e.state = m_state;
    e.rise  = m_rise;
    e.fall  = m_fall;
    e.any   = |(m_rise | m_fall);
    e.idx   = m_idx;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: the DUT presents a new output set after every edge.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_underflow: no expected entry at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
      check("sb_outputs", {sw_state, sw_rise, sw_fall, sw_any, last_idx}, e);
`else
      check("sb_outputs", {sw_state, sw_rise, sw_fall, sw_any},
            {e.state, e.rise, e.fall, e.any});
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed + random stimulus (driven on negedges)
  // ---------------------------------------------------------------------------
  task automatic wait_rise(input int b, input string name, input int exp_edges);
    int seen;
    seen = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (sw_rise[b]) begin
        seen = i;
        break;
      end
    end
    check(name, 64'(seen), 64'(exp_edges));
  endtask

  initial begin
    // Reset with all switches low.
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {sw_state, sw_rise, sw_fall, sw_any}, '0);
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
    check("reset_idx", last_idx, 5'd20);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_state", sw_state, '0);

    // Clean rise on bit 3.
    stswi[3] = 1'b1;
    wait_rise(3, "rise3_latency", 6);
    check("rise3_state", sw_state[3], 1'b1);
    check("rise3_any", sw_any, 1'b1);
    @(posedge clk);
    #1;
    check("rise3_one_cycle", sw_rise[3], 1'b0);
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
    check("rise3_idx", last_idx, 5'd3);
`endif

    // Bounce on bit 0, then settle low.
    @(negedge clk);
    stswi[0] = 1'b1;
    repeat (11) begin
      @(negedge clk);
      stswi[0] = ~stswi[0];
    end
    @(negedge clk);
    stswi[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_state0", sw_state[0], 1'b0);

    // Three-cycle glitch on bit 1, then a real hold.
    stswi[1] = 1'b1;
    repeat (3) @(negedge clk);
    stswi[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_state1", sw_state[1], 1'b0);
    stswi[1] = 1'b1;
    wait_rise(1, "hold1_latency", 6);

    // Simultaneous rise on bits 2 and 7.
    @(negedge clk);
    stswi[2] = 1'b1;
    stswi[7] = 1'b1;
    wait_rise(2, "rise27_latency", 6);
    check("rise27_pair", {sw_rise[7], sw_rise[2]}, 2'b11);
    check("rise27_any", sw_any, 1'b1);
    @(posedge clk);
    #1;
    check("rise27_any_single", sw_any, 1'b0);
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
    check("rise27_idx", last_idx, 5'd2);
`endif

    // Reset while bit 5 is mid-count (counter at 3 after five edges).
    @(negedge clk);
    stswi[5] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_clear", {sw_state, sw_rise, sw_fall, sw_any}, '0);
`ifdef SWITCH_DEBOUNCE_LASTIDX_EN
    check("midrst_idx", last_idx, 5'd20);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_rise(5, "postrst_rise5", 6);

    // Randomised flips, roughly one per bit every eight cycles.
    repeat (600) begin
      @(negedge clk);
      for (int b = 0; b < W; b++) if ($urandom_range(7) == 0) stswi[b] = ~stswi[b];
    end
    repeat (DB + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Input-conditioning block for the slide switches; the receive side of the switch interface. It synchronises the raw `stswi` pins into the clock domain and filters contact bounce per switch. It outputs a stable switch vector plus one-cycle rise/fall event pulses for the clocked demos, replacing direct pin-to-LED wiring. An optional readout reports the last-changed switch index in the code format the `hexdigit` 7-seg driver accepts.

## Interface
- `WIDTH`, 10: number of switches.
- `DB_CYCLES`, 250000: consecutive stable cycles required to accept a new level (5 ms at 50 MHz); legal range 2..2^24-1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stswi`  in  WIDTH  raw slide-switch pins, asynchronous to `clk`.
- `sw_state`  out  WIDTH  debounced switch levels.
- `sw_rise`  out  WIDTH  one-cycle pulse per bit on an accepted 0→1 change.
- `sw_fall`  out  WIDTH  one-cycle pulse per bit on an accepted 1→0 change.
- `sw_any`  out  1  OR of all `sw_rise | sw_fall` bits, same cycle.
- `last_idx`  out  5  present only with `SWITCH_DEBOUNCE_LASTIDX_EN`; index of the last changed switch.

## Operation
- Reset values: synchroniser flops 0, `sw_state` 0, all counters 0, `sw_rise`/`sw_fall`/`sw_any` 0, `last_idx` 20 (the hexdigit "blank" code).
- Each bit passes through a 2-flop synchroniser to give `s[i]`.
- Per-bit counter rule, evaluated every cycle:
  - If `s[i] == sw_state[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals `DB_CYCLES-1` and `s[i]` still differs, the block sets `sw_state[i] <= s[i]` and clears the counter. On the same edge it pulses `sw_rise[i]` or `sw_fall[i]` for exactly one cycle.
- A glitch shorter than `DB_CYCLES` cycles returns the counter to 0 and produces no event.
- Switches held on through reset produce a rise event `DB_CYCLES+2` cycles after reset release, because the state resets to 0. This is intended.
- Bits are independent. Several bits may pulse in the same cycle, and `sw_any` asserts once for that cycle.
- Counter width is `$clog2(DB_CYCLES)`. The counter never reaches `DB_CYCLES` and so never wraps.
- If `rst` asserts mid-count, all state clears immediately and no pulse is emitted.

## Timing
- Latency from a clean pin transition to the `sw_state` change: 2 synchroniser edges plus `DB_CYCLES` edges.
- All outputs are registered, with no combinational path from `stswi`.
- Pulses are coincident with the corresponding `sw_state` update. They are high for exactly one `clk` cycle.
- `sw_any` is registered and aligned with the pulses. It is not delayed by a cycle.

## Configuration
- `SWITCH_DEBOUNCE_LASTIDX_EN` defined:
  - The `last_idx` port exists.
  - On any cycle with `sw_any`, it loads the lowest index `i` with `sw_rise[i]` set, if any. Otherwise it loads the lowest index with `sw_fall[i]` set.
  - The update lands on the edge after the pulse (1-cycle latency), and the value then holds.
  - Reset value is 20.
- Macro undefined: the port and its register are absent, and all other behaviour is identical.

## Structure
- Package `switch_debounce_pkg` holds:
  - `SWDB_DB_CYCLES_DEFAULT` = 250000
  - `SWDB_IDX_OFF` = 5'd20
  - `SWDB_WIDTH_DEFAULT` = 10
- Sub-module `switch_debounce_bit` holds the synchroniser, counter, state flop and rise/fall pulse logic for one bit. The top instantiates it `WIDTH` times with a generate loop and adds the `sw_any` OR and the optional `last_idx` priority logic.

## Test plan
Bench uses `DB_CYCLES=4`, `WIDTH=10`.
- Reset with `stswi=0`: all outputs 0 and `last_idx`=20 during reset and after it; no pulses for 20 cycles.
- Set `stswi[3]` to 1 and hold: `sw_state[3]`=1 and `sw_rise[3]`=1 for exactly one cycle, 6 edges after the change; `sw_any`=1 in that cycle; `last_idx`=3 on the next edge.
- Toggle `stswi[0]` 1/0/1/0 every cycle for 12 cycles (bounce), then hold 0: no pulses and `sw_state[0]` stays 0.
- Hold `stswi[1]` high for 3 cycles only: no event and the counter returns to 0. Then hold it for 4+ cycles: exactly one rise.
- Raise `stswi[2]` and `stswi[7]` on the same edge: both rise pulses in the same cycle, a single `sw_any` cycle, `last_idx`=2.
- Assert `rst` while `stswi[5]` is high and its count is 3: outputs clear at once with no pulse. After release, the rise on bit 5 arrives 6 edges later.
